// File: rtl/vm_pkg.sv
// Shared voting-machine definitions: report framing constants, serial state
// encoding and the winner selection rule.
package vm_pkg;

    localparam logic [7:0] REPORT_HEADER = 8'hA5;
    localparam int         REPORT_BYTES  = 7;
    localparam logic [7:0] WINNER_TIE    = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // votes[0] is candidate 1; a later candidate wins only by strictly beating the max.
    function automatic logic [7:0] calc_winner(input logic [3:0][7:0] votes);
        logic [7:0] max_v;
        logic [2:0] idx;
        logic       tie;
        max_v = votes[0];
        idx   = 3'd1;
        tie   = 1'b0;
        for (int unsigned i = 1; i < 4; i++) begin
            if (votes[i] > max_v) begin
                max_v = votes[i];
                idx   = 3'(i + 1);
                tie   = 1'b0;
            end else if (votes[i] == max_v) begin
                tie = 1'b1;
            end
        end
        return tie ? WINNER_TIE : {5'b0, idx};
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser with registered line output; accepts a new byte in the
// final stop-bit cycle so consecutive bytes run with no idle gap.
module uart_byte_tx
    import vm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       start,
    output logic       ready,
    output logic       tx
);

    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_LAST);
    assign ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign tx      = tx_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else if (start && ready) begin
            state_q <= START;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= byte_in;
            tx_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state_q <= IDLE;
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vote_report_tx.sv
// Results report transmitter: snapshots the four tallies on an accepted view-mode
// request and sends header, tallies, winner and checksum as one 7-byte frame.
module vote_report_tx
    import vm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       report_req,
    input  logic [7:0] cand1_votes,
    input  logic [7:0] cand2_votes,
    input  logic [7:0] cand3_votes,
    input  logic [7:0] cand4_votes,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] LAST_IDX = 3'(REPORT_BYTES - 1);

    logic [3:0][7:0] snap_q;
    logic [2:0]      byte_idx_q;
    logic            busy_q;
    logic            done_q;

    logic [7:0] winner;
    logic [7:0] checksum;
    logic [7:0] byte_sel;
    logic [2:0] next_idx;
    logic       accept;
    logic       byte_ready;
    logic       advance;
    logic       finish;

    assign winner   = calc_winner(snap_q);
    assign checksum = snap_q[0] ^ snap_q[1] ^ snap_q[2] ^ snap_q[3] ^ winner;

    assign accept  = report_req && mode && !busy_q;
    assign advance = busy_q && byte_ready && (byte_idx_q != LAST_IDX);
    assign finish  = busy_q && byte_ready && (byte_idx_q == LAST_IDX);

    // The header goes out on the accept cycle itself, before the snapshot registers load.
    always_comb begin
        next_idx = byte_idx_q + 3'd1;
        byte_sel = REPORT_HEADER;
        if (!accept) begin
            case (next_idx)
                3'd1:    byte_sel = snap_q[0];
                3'd2:    byte_sel = snap_q[1];
                3'd3:    byte_sel = snap_q[2];
                3'd4:    byte_sel = snap_q[3];
                3'd5:    byte_sel = winner;
                3'd6:    byte_sel = checksum;
                default: byte_sel = REPORT_HEADER;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            snap_q     <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= finish;
            if (accept) begin
                snap_q     <= {cand4_votes, cand3_votes, cand2_votes, cand1_votes};
                byte_idx_q <= '0;
                busy_q     <= 1'b1;
            end else if (advance) begin
                byte_idx_q <= next_idx;
            end else if (finish) begin
                byte_idx_q <= '0;
                busy_q     <= 1'b0;
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clock  (clock),
        .reset  (reset),
        .byte_in(byte_sel),
        .start  (accept || advance),
        .ready  (byte_ready),
        .tx     (tx)
    );

    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_vote_report_tx.sv
// Directed bench for vote_report_tx with a bit-stream reference model checked every cycle.
module tb_vote_report_tx;

    localparam int C  = 4;
    localparam int FL = 70 * C;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mode = 1'b0;
    logic       report_req = 1'b0;
    logic [7:0] cand1_votes = '0, cand2_votes = '0, cand3_votes = '0, cand4_votes = '0;
    logic       tx, busy, frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    vote_report_tx #(.CLKS_PER_BIT(C)) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .report_req (report_req),
        .cand1_votes(cand1_votes),
        .cand2_votes(cand2_votes),
        .cand3_votes(cand3_votes),
        .cand4_votes(cand4_votes),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame bytes, byte 0 in bits [7:0].
    function automatic logic [55:0] build_frame(input logic [7:0] a, b, c, d);
        logic [7:0] v [4];
        logic [7:0] fr [7];
        int mx, cnt, w;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        mx = 0; cnt = 0; w = 0;
        for (int i = 0; i < 4; i++) if (int'(v[i]) > mx) mx = int'(v[i]);
        for (int i = 0; i < 4; i++) if (int'(v[i]) == mx) begin cnt++; w = i + 1; end
        fr[0] = 8'hA5;
        for (int i = 0; i < 4; i++) fr[i+1] = v[i];
        fr[5] = (cnt == 1) ? 8'(w) : 8'h00;
        fr[6] = fr[1] ^ fr[2] ^ fr[3] ^ fr[4] ^ fr[5];
        return {fr[6], fr[5], fr[4], fr[3], fr[2], fr[1], fr[0]};
    endfunction

    // Reference model: per-cycle expected line level queued on acceptance.
    logic m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    logic mq [$];

    always @(posedge clock) begin
        logic [55:0] fr;
        logic [7:0]  bv;
        logic        lvl;
        if (reset) begin
            mq.delete();
            m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            if (report_req && mode && !m_busy) begin
                fr = build_frame(cand1_votes, cand2_votes, cand3_votes, cand4_votes);
                for (int k = 0; k < 7; k++) begin
                    bv = fr[8*k +: 8];
                    for (int b = 0; b < 10; b++) begin
                        lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bv[b-1];
                        for (int r = 0; r < C; r++) mq.push_back(lvl);
                    end
                end
            end
            if (mq.size() > 0) begin
                m_tx = mq.pop_front(); m_busy = 1'b1; m_done = 1'b0;
            end else if (m_busy) begin
                m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b1;
            end else begin
                m_tx = 1'b1; m_done = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_tx", {63'b0, tx}, {63'b0, m_tx});
            check("model_busy", {63'b0, busy}, {63'b0, m_busy});
            check("model_frame_done", {63'b0, frame_done}, {63'b0, m_done});
        end
    end

    // Called at a negedge; returns at a negedge after the frame window.
    task automatic run_frame(input logic [7:0] a, b, c, d, input int chg_at, input int req_at,
                             output logic [55:0] got, output int lat, output int ndone);
        logic s [FL];
        cand1_votes = a; cand2_votes = b; cand3_votes = c; cand4_votes = d;
        mode = 1'b1; report_req = 1'b1;
        @(posedge clock);
        lat = -1; ndone = 0;
        for (int i = 1; i <= FL + 6; i++) begin
            @(negedge clock);
            if (i <= FL) s[i-1] = tx;
            if (frame_done) begin ndone++; if (lat < 0) lat = i; end
            if (i == 1) report_req = 1'b0;
            if (i == req_at) report_req = 1'b1;
            if (i == req_at + 1) report_req = 1'b0;
            if (i == chg_at) begin
                cand1_votes = 8'd10; cand2_votes = 8'd10; cand3_votes = 8'd10; cand4_votes = 8'd10;
                mode = 1'b0;
            end
        end
        got = '0;
        for (int k = 0; k < 7; k++)
            for (int j = 0; j < 8; j++)
                got[8*k + j] = s[(k*10 + j + 1)*C + C/2];
    endtask

    logic [55:0] got;
    int lat, ndone, cnt;

    initial begin
        // Literal pins on the model's frame builder.
        check("model_nominal", {8'h0, build_frame(8'd3, 8'd7, 8'd2, 8'd5)}, 64'h01_02_05_02_07_03_A5);
        check("model_tie", {8'h0, build_frame(8'd9, 8'd9, 8'd1, 8'd0)}, 64'h01_00_00_01_09_09_A5);
        check("model_zero", {8'h0, build_frame(8'd0, 8'd0, 8'd0, 8'd0)}, 64'h00_00_00_00_00_00_A5);

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_tx", {63'b0, tx}, 64'd1);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, frame_done}, 64'd0);
        repeat (2) @(negedge clock);

        run_frame(8'd3, 8'd7, 8'd2, 8'd5, -10, -10, got, lat, ndone);
        check("nominal_bytes", {8'h0, got}, 64'h01_02_05_02_07_03_A5);
        check("nominal_latency", 64'(lat), 64'd281);
        check("nominal_done_count", 64'(ndone), 64'd1);

        run_frame(8'd9, 8'd9, 8'd1, 8'd0, -10, -10, got, lat, ndone);
        check("tie_bytes", {8'h0, got}, 64'h01_00_00_01_09_09_A5);
        run_frame(8'd0, 8'd0, 8'd0, 8'd0, -10, -10, got, lat, ndone);
        check("zero_bytes", {8'h0, got}, 64'h00_00_00_00_00_00_A5);

        // Request in vote mode is dropped.
        mode = 1'b0; report_req = 1'b1;
        @(negedge clock);
        report_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (busy || !tx || frame_done) cnt++;
        end
        check("gated_activity", 64'(cnt), 64'd0);

        run_frame(8'd3, 8'd7, 8'd2, 8'd5, -10, 50, got, lat, ndone);
        check("busy_req_bytes", {8'h0, got}, 64'h01_02_05_02_07_03_A5);
        check("busy_req_done_count", 64'(ndone), 64'd1);
        check("busy_req_latency", 64'(lat), 64'd281);

        run_frame(8'd3, 8'd7, 8'd2, 8'd5, 30, -10, got, lat, ndone);
        check("snapshot_bytes", {8'h0, got}, 64'h01_02_05_02_07_03_A5);
        check("snapshot_latency", 64'(lat), 64'd281);

        // Reset at cycle 100 of a frame.
        mode = 1'b1; report_req = 1'b1;
        cand1_votes = 8'd3; cand2_votes = 8'd7; cand3_votes = 8'd2; cand4_votes = 8'd5;
        @(negedge clock);
        report_req = 1'b0;
        repeat (99) @(negedge clock);
        check("pre_reset_busy", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_tx", {63'b0, tx}, 64'd1);
        check("midreset_busy", {63'b0, busy}, 64'd0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (frame_done) cnt++;
        end
        check("midreset_no_done", 64'(cnt), 64'd0);
        run_frame(8'd3, 8'd7, 8'd2, 8'd5, -10, -10, got, lat, ndone);
        check("post_reset_bytes", {8'h0, got}, 64'h01_02_05_02_07_03_A5);
        check("post_reset_latency", 64'(lat), 64'd281);

        // Back-to-back: request held through the frame_done cycle.
        cand1_votes = 8'd1; cand2_votes = 8'd2; cand3_votes = 8'd3; cand4_votes = 8'd4;
        mode = 1'b1; report_req = 1'b1;
        @(posedge clock);
        lat = -1;
        for (int i = 1; i <= FL + 20 && lat < 0; i++) begin
            @(negedge clock);
            if (frame_done) lat = i;
        end
        check("b2b_first_latency", 64'(lat), 64'd281);
        @(negedge clock);
        report_req = 1'b0;
        check("b2b_second_start_tx", {63'b0, tx}, 64'd0);
        check("b2b_second_busy", {63'b0, busy}, 64'd1);
        lat = -1;
        for (int i = 2; i <= FL + 20 && lat < 0; i++) begin
            @(negedge clock);
            if (frame_done) lat = i;
        end
        check("b2b_second_latency", 64'(lat), 64'd281);
        repeat (5) @(negedge clock);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vote_report_tx.md
# vote_report_tx

Serial results transmitter for the voting machine. In view mode, on request, it snapshots the four 8-bit candidate tallies produced by the vote logger and computes the winner. It then sends a framed, checksummed report over a UART-style 8N1 line to an external host or display controller. It reads the tallies that the logger writes and sits beside the LED mode controller at the top level.

## Interface

Parameters:
- CLKS_PER_BIT, default 10: clock cycles per serial bit; legal values are 2 or more.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- mode  in  1  0 = vote mode, 1 = view mode; reports are only started in view mode
- report_req  in  1  single-cycle request strobe to start a frame
- cand1_votes, cand2_votes, cand3_votes, cand4_votes  in  8 each  live tallies
- tx  out  1  serial line, idles high
- busy  out  1  high while a frame is in flight
- frame_done  out  1  one-cycle pulse when a frame completes

## Operation

- Frame is 7 bytes, in order:
  - 0xA5 header
  - c1, c2, c3, c4
  - winner
  - checksum
- Winner byte is 0x01–0x04 for the unique maximum candidate. It is 0x00 if two or more candidates share the maximum, including the all-zero case.
- Checksum is the XOR of bytes 1–5 (c1 through winner). The header is excluded.
- Each byte is sent as start bit (0), 8 data bits LSB first, then stop bit (1). Every bit lasts exactly CLKS_PER_BIT cycles. There is no idle gap between bytes.
- Request acceptance:
  - A request is accepted only when report_req=1, mode=1 and busy=0.
  - All other requests are dropped and have no queueing or side effect.
- On acceptance, the four tallies are captured into snapshot registers and winner/checksum are derived from the snapshot. Later tally changes do not affect the frame in flight.
- Once started, mode changes do not abort or alter a frame. Mode gates only the start.
- State machine: IDLE → START → DATA → STOP.
  - From STOP: go to START if the byte index is below 6, else back to IDLE.
  - Byte index runs 0–6 and bit index 0–7.
  - Baud counter runs 0 to CLKS_PER_BIT-1 and wraps.
- Reset values: tx=1, busy=0, frame_done=0. State is IDLE, all counters are 0, snapshots are 0.
- Reset mid-frame aborts the frame. tx=1 and busy=0 after the next edge, and frame_done is not pulsed.

## Timing

- If report_req is accepted at the edge ending cycle N:
  - busy=1 and tx=0 (header start bit) from cycle N+1.
  - Frame occupies cycles N+1 through N+70·CLKS_PER_BIT.
- At cycle N+70·CLKS_PER_BIT+1: frame_done=1 for exactly one cycle and busy=0 in the same cycle.
- A request arriving in the frame_done cycle is accepted, giving back-to-back frames.
- tx is driven from a register (glitch-free). Latency from a bit-boundary decision to tx change is 0 cycles relative to the counter wrap.
- Arithmetic:
  - Tallies are unsigned 8-bit.
  - Winner compare uses strict greater-than over snapshots, with a tie flag.
  - No counter may exceed its range; all wrap explicitly.

## Structure

- Shared package vm_pkg holds:
  - REPORT_HEADER = 8'hA5
  - REPORT_BYTES = 7
  - WINNER_TIE = 8'h00
  - the state enum (IDLE/START/DATA/STOP), for reuse by a future receiver model
- One sub-module is natural: uart_byte_tx.
  - It contains the baud counter and bit shifter, with ports byte_in[7:0], start, ready, tx.
  - The parent holds the snapshot, winner/checksum, byte index and frame sequencing.
  - Byte-to-byte handoff must add no idle cycles. uart_byte_tx accepts its next start in the last stop-bit cycle.

## Test plan

Use CLKS_PER_BIT=4 for all scenarios.
- Nominal frame: mode=1, tallies 3,7,2,5, pulse req → bytes A5 03 07 02 05 02 01; frame_done exactly 281 cycles after the accept edge.
- Tie: tallies 9,9,1,0 → winner byte 00, checksum 01. All-zero tallies → winner 00, checksum 00.
- Gating: req with mode=0 → tx stays 1 and busy stays 0 for 300 cycles. A second req while busy → ignored, single frame only.
- Snapshot and mode independence: tallies 3,7,2,5 at accept, then change tallies to 10,10,10,10 and mode to 0 mid-frame → transmitted bytes are unchanged from the nominal frame.
- Reset mid-frame: assert reset at cycle 100 of a frame → tx=1 and busy=0 on the next cycle, and no frame_done. A subsequent req yields a full, correct frame.
- Back-to-back: req held high across the frame_done cycle → second frame starts immediately with no idle bit between the frames.
